// File: rtl/nabp_pkg.sv
// Shared NABP constants and the sweep sequencer state encoding.
// The shifter and the angle LUT use the same sizing constants.
package nabp_pkg;

  localparam int NO_OF_ANGLES = 180;
  localparam int ANGLE_WIDTH  = 8;
  localparam int ACCU_WIDTH   = 16;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_LATCH,
    ST_FILL_KICK,
    ST_FILL_WAIT,
    ST_SHIFT_WAIT_PE,
    ST_SHIFT_KICK,
    ST_SHIFT_WAIT,
    ST_NEXT,
    ST_DONE
  } sweep_state_t;

endpackage

// File: rtl/nabp_sweep_control.sv
// Per-projection sweep sequencer: LUT fetch, then fill/shift kick handshake per angle.
// Moore outputs; kick->fill_kick 3 cycles; stalls in SHIFT_WAIT_PE while pe_ready is low.
module nabp_sweep_control #(
  parameter int NO_OF_ANGLES = nabp_pkg::NO_OF_ANGLES,
  parameter int ANGLE_WIDTH  = nabp_pkg::ANGLE_WIDTH,
  parameter int ACCU_WIDTH   = nabp_pkg::ACCU_WIDTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   hs_kick,
  output logic                   hs_done,
  output logic                   hs_busy,
  output logic [ANGLE_WIDTH-1:0] lut_angle,
  input  logic [ACCU_WIDTH-1:0]  lut_accu_base,
  output logic [ACCU_WIDTH-1:0]  sc_accu_base,
  output logic                   sc_fill_kick,
  output logic                   sc_shift_kick,
  input  logic                   sc_fill_done,
  input  logic                   sc_shift_done,
  input  logic                   pe_ready,
  output logic [ANGLE_WIDTH-1:0] angle,
  output logic                   err_done
);

  import nabp_pkg::*;

  localparam logic [ANGLE_WIDTH-1:0] LAST_ANGLE = ANGLE_WIDTH'(NO_OF_ANGLES - 1);

  sweep_state_t state, state_nxt;
  logic         spurious_done;

  // A done pulse is only legal in its own wait state; anything else is a shifter protocol error.
  assign spurious_done = (sc_fill_done  && (state != ST_FILL_WAIT)) ||
                         (sc_shift_done && (state != ST_SHIFT_WAIT));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      angle        <= '0;
      sc_accu_base <= '0;
      err_done     <= 1'b0;
    end else begin
      state <= state_nxt;
      if ((state == ST_IDLE) && hs_kick) begin
        angle <= '0;
      end else if ((state == ST_NEXT) && (angle != LAST_ANGLE)) begin
        angle <= angle + 1'b1;
      end
      if (state == ST_LATCH) begin
        sc_accu_base <= lut_accu_base;
      end
      if (spurious_done) begin
        err_done <= 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:          if (hs_kick) state_nxt = ST_LOOKUP;
      ST_LOOKUP:        state_nxt = ST_LATCH;
      ST_LATCH:         state_nxt = ST_FILL_KICK;
      ST_FILL_KICK:     state_nxt = ST_FILL_WAIT;
      ST_FILL_WAIT:     if (sc_fill_done) state_nxt = ST_SHIFT_WAIT_PE;
      ST_SHIFT_WAIT_PE: if (pe_ready) state_nxt = ST_SHIFT_KICK;
      ST_SHIFT_KICK:    state_nxt = ST_SHIFT_WAIT;
      ST_SHIFT_WAIT:    if (sc_shift_done) state_nxt = ST_NEXT;
      ST_NEXT:          state_nxt = (angle == LAST_ANGLE) ? ST_DONE : ST_LOOKUP;
      ST_DONE:          state_nxt = ST_IDLE;
      default:          state_nxt = ST_IDLE;
    endcase
  end

  assign lut_angle     = angle;
  assign hs_busy       = (state != ST_IDLE);
  assign hs_done       = (state == ST_DONE);
  assign sc_fill_kick  = (state == ST_FILL_KICK);
  assign sc_shift_kick = (state == ST_SHIFT_KICK);

endmodule
